skein_key_inject: RTL and testbench
===================================

# skein_key_inject

Threefish-1024 subkey injection stage for the Skein pipeline. It adds subkey S to the 16-word state and emits the result to the next four-round group (even or odd round block). It also carries the extended key and tweak forward through a delay line, so they arrive aligned with that state at the next injection stage. With FIRST=1 it also builds the extended key: parity word k16 and tweak word t2.

## Interface
- S, 0: subkey index, 0..20; fixed per instance.
- FIRST, 0: 1 = compute k16 and t2 from the inputs and ignore the input k16/t2 words; 0 = use the input words as given.
- KEY_DELAY, 3: extra register stages on the key/tweak path, matching the latency of the downstream round group.
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in/key_in/tweak_in valid this cycle.
- state_in  input  1024  state; word i at bits [64i+63:64i].
- key_in  input  1088  extended key k0..k16, word j at [64j+63:64j].
- tweak_in  input  192  t0..t2.
- out_valid  output  1  state_out valid.
- state_out  output  1024  injected state.
- key_valid  output  1  key_out/tweak_out valid.
- key_out  output  1088  extended key, delayed.
- tweak_out  output  192  tweak, delayed.

## Operation
- Extended key, FIRST=1:
  - k16 = 0x1BD11BDAA9FC1A22 ^ k0 ^ ... ^ k15.
  - t2 = t0 ^ t1.
  - Computed combinationally from the inputs.
- Extended key, FIRST=0: k16 and t2 are taken from key_in/tweak_in.
- Injection, for i = 0..15, all additions mod 2^64 with carries discarded:
  - out[i] = in[i] + k[(S+i) mod 17].
  - out[13] additionally + t[S mod 3].
  - out[14] additionally + t[(S+1) mod 3].
  - out[15] additionally + S, as a 64-bit zero-extended constant.
- Indices are elaboration-time constants; no runtime muxing.
- State path: one register stage.
  - On each rising edge, out_valid <= in_valid and state_out <= injected value.
  - Data registers load every cycle regardless of in_valid; consumers qualify with out_valid.
- Key path: shift register of 1+KEY_DELAY stages carrying {valid, key, tweak}.
  - The key and tweak entering the line are the extended versions, with k16/t2 computed when FIRST=1.
  - Stage 0 loads in the same cycle as the state register.
  - key_valid/key_out/tweak_out are taken from the last stage.
- No backpressure: the pipeline is free-running and accepts a new input every cycle.

## Timing
- Reset (nrst low, asynchronous): out_valid, key_valid, state_out, key_out, tweak_out and every key-line stage go to 0 immediately. This holds even mid-stream.
- Release: first capture on the first rising edge with nrst high.
- Input accepted in cycle n gives:
  - state_out/out_valid in cycle n+1.
  - key_out/tweak_out/key_valid in cycle n+1+KEY_DELAY.
- With the default KEY_DELAY=3, the key reaches the next injection stage together with the state leaving the 3-cycle round group.
- Back-to-back inputs produce back-to-back outputs with no bubbles.
- Bubbles (in_valid=0) propagate as valid=0 on both paths. Data during bubbles is don't-care.
- Wrap-around: any word sum ≥ 2^64 wraps silently. No carry propagates between words.
- Reset asserted while entries are in the key line: all entries are lost, and key_valid stays 0 until 1+KEY_DELAY cycles after the next accepted input.

## Test plan
- All-zero state/key/tweak, FIRST=1, S=1, one valid beat:
  - state_out word15 = 0x1BD11BDAA9FC1A23; all other words 0.
  - out_valid high exactly one cycle, 1 cycle after input.
- Key words k_i = i (i = 0..15), t0 = 0x10, t1 = 0x20, zero state, FIRST=1, S=0:
  - words 0..12 = i; word13 = 0x1D; word14 = 0x2E; word15 = 0x0F.
  - Key line: k16 = 0x1BD11BDAA9FC1A22 and t2 = 0x30 on key_out/tweak_out 4 cycles after input.
- Wrap: state word0 = 0xFFFFFFFFFFFFFFFF, k0 = 1, all else zero, FIRST=0, S=0:
  - word0 = 0; word1 = 0 (no carry into it).
- Rotation, FIRST=0, S=18, k_j = j+1 (k16 = 17), t = {0x100, 0x200, 0x300}, zero state:
  - word i = k[(18+i) mod 17], e.g. word0 = 2 and word15 = k16 = 17.
  - word13 = k14 + 0x100 = 0x10F; word14 = k15 + 0x200 = 0x210; word15 = 17 + 18 = 0x23.
- Streaming: 8 consecutive valid beats with a bubble at beat 4:
  - out_valid pattern 11101111 starts 1 cycle later.
  - key_valid shows the same pattern, starting 4 cycles later.
- Reset mid-stream, nrst pulsed low between clock edges during streaming:
  - all outputs read 0 before the next edge.
  - no stale key_valid after release.

Source files
------------

// File: rtl/skein_key_inject.sv
// Threefish-1024 subkey injection stage.
// Adds subkey S to the 16-word state in one register stage. The extended
// key/tweak travels a parallel delay line so it arrives at the next injection
// stage together with the state leaving the downstream round group.
module skein_key_inject #(
  parameter int S         = 0,
  parameter int FIRST     = 0,
  parameter int KEY_DELAY = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  input  logic [1023:0] state_in,
  input  logic [1087:0] key_in,
  input  logic [191:0]  tweak_in,
  output logic          out_valid,
  output logic [1023:0] state_out,
  output logic          key_valid,
  output logic [1087:0] key_out,
  output logic [191:0]  tweak_out
);

  // Threefish key-schedule parity constant
  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  logic [63:0]   k16_calc;
  logic [1087:0] key_ext;
  logic [191:0]  tweak_ext;
  logic [1023:0] state_next;

  // Parity word over k0..k15, only selected when this stage builds the key
  always_comb begin
    k16_calc = C240;
    for (int j = 0; j < 16; j++) begin
      k16_calc = k16_calc ^ key_in[64*j +: 64];
    end
  end

  // Extended key/tweak: derived words replace the input ones on the first stage
  always_comb begin
    key_ext   = key_in;
    tweak_ext = tweak_in;
    if (FIRST != 0) begin
      key_ext[1087:1024] = k16_calc;
      tweak_ext[191:128] = tweak_in[63:0] ^ tweak_in[127:64];
    end
  end

  // Per-word injection; every key/tweak index is fixed at elaboration
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      localparam int          KI = (S + gi) % 17;
      localparam int          TI = (gi == 13) ? (S % 3) : ((S + 1) % 3);
      localparam logic [63:0] SC = (gi == 15) ? 64'(S) : 64'd0;
      logic [63:0] tadd;
      if (gi == 13 || gi == 14) begin : g_tw
        assign tadd = tweak_ext[64*TI +: 64];
      end else begin : g_notw
        assign tadd = 64'd0;
      end
      assign state_next[64*gi +: 64] = state_in[64*gi +: 64]
                                     + key_ext[64*KI +: 64]
                                     + tadd + SC;
    end
  endgenerate

  logic          out_valid_reg;
  logic [1023:0] state_reg;

  // State path: single register stage, data loads every cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_reg <= 1'b0;
      state_reg     <= '0;
    end else begin
      out_valid_reg <= in_valid;
      state_reg     <= state_next;
    end
  end

  logic          kv_reg  [0:KEY_DELAY];
  logic [1087:0] key_reg [0:KEY_DELAY];
  logic [191:0]  tw_reg  [0:KEY_DELAY];

  // Key path: 1+KEY_DELAY stage shift line of {valid, key, tweak}
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j <= KEY_DELAY; j++) begin
        kv_reg[j]  <= 1'b0;
        key_reg[j] <= '0;
        tw_reg[j]  <= '0;
      end
    end else begin
      kv_reg[0]  <= in_valid;
      key_reg[0] <= key_ext;
      tw_reg[0]  <= tweak_ext;
      for (int j = 1; j <= KEY_DELAY; j++) begin
        kv_reg[j]  <= kv_reg[j-1];
        key_reg[j] <= key_reg[j-1];
        tw_reg[j]  <= tw_reg[j-1];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign state_out = state_reg;
  assign key_valid = kv_reg[KEY_DELAY];
  assign key_out   = key_reg[KEY_DELAY];
  assign tweak_out = tw_reg[KEY_DELAY];

endmodule

// File: tb/tb_skein_key_inject.sv
// Directed bench for skein_key_inject: four instances with different S/FIRST
// share one input bus; each vector is checked on the instance it targets.
module tb_skein_key_inject;

  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1023:0] state_in = '0;
  logic [1087:0] key_in = '0;
  logic [191:0]  tweak_in = '0;

  // u1: S=1 FIRST=1 | uf: S=0 FIRST=1 | up: S=0 FIRST=0 | u18: S=18 FIRST=0
  logic u1_ov, uf_ov, up_ov, u18_ov;
  logic u1_kv, uf_kv, up_kv, u18_kv;
  logic [1023:0] u1_so, uf_so, up_so, u18_so;
  logic [1087:0] u1_ko, uf_ko, up_ko, u18_ko;
  logic [191:0]  u1_to, uf_to, up_to, u18_to;

  skein_key_inject #(.S(1), .FIRST(1), .KEY_DELAY(3)) u1 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .state_in(state_in),
    .key_in(key_in), .tweak_in(tweak_in), .out_valid(u1_ov), .state_out(u1_so),
    .key_valid(u1_kv), .key_out(u1_ko), .tweak_out(u1_to));
  skein_key_inject #(.S(0), .FIRST(1), .KEY_DELAY(3)) uf (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .state_in(state_in),
    .key_in(key_in), .tweak_in(tweak_in), .out_valid(uf_ov), .state_out(uf_so),
    .key_valid(uf_kv), .key_out(uf_ko), .tweak_out(uf_to));
  skein_key_inject #(.S(0), .FIRST(0), .KEY_DELAY(3)) up (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .state_in(state_in),
    .key_in(key_in), .tweak_in(tweak_in), .out_valid(up_ov), .state_out(up_so),
    .key_valid(up_kv), .key_out(up_ko), .tweak_out(up_to));
  skein_key_inject #(.S(18), .FIRST(0), .KEY_DELAY(3)) u18 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .state_in(state_in),
    .key_in(key_in), .tweak_in(tweak_in), .out_valid(u18_ov), .state_out(u18_so),
    .key_valid(u18_kv), .key_out(u18_ko), .tweak_out(u18_to));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    state_in = '0;
    key_in   = '0;
    tweak_in = '0;
  endtask

  function automatic logic [63:0] w16(input logic [1023:0] v, input int i);
    return v[64*i +: 64];
  endfunction

  function automatic logic [63:0] w17(input logic [1087:0] v, input int i);
    return v[64*i +: 64];
  endfunction

  function automatic logic [63:0] all_zero_flag(input logic u1o, input logic u1k,
      input logic [1023:0] so, input logic [1087:0] ko, input logic [191:0] to);
    return {59'd0, u1o, u1k, |so, |ko, |to};
  endfunction

  logic [63:0] exp_w;
  bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // ---------------- reset state ----------------
    #1 nrst = 1'b0;
    #1;
    chk("reset_u1", all_zero_flag(u1_ov, u1_kv, u1_so, u1_ko, u1_to), 64'd0);
    chk("reset_u18", all_zero_flag(u18_ov, u18_kv, u18_so, u18_ko, u18_to), 64'd0);
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    $display("reset released at %0t", $time);

    // ---------------- vector 1: all zero, S=1 FIRST=1 ----------------
    @(negedge clk);
    clear_inputs();
    in_valid = 1'b1;
    @(posedge clk); #1;
    $display("vec1 all-zero S=1: word15=%h", w16(u1_so, 15));
    chk("v1_ov", {63'd0, u1_ov}, 64'd1);
    chk("v1_w15", w16(u1_so, 15), 64'h1BD11BDAA9FC1A23);
    for (int i = 0; i < 15; i++) chk($sformatf("v1_w%0d", i), w16(u1_so, i), 64'd0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("v1_ov_drop", {63'd0, u1_ov}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("v1_kv_pulse", {63'd0, u1_kv}, 64'd1);

    // ---------------- vector 2: k_i=i, S=0 FIRST=1 ----------------
    @(negedge clk);
    clear_inputs();
    for (int j = 0; j < 16; j++) key_in[64*j +: 64] = 64'(j);
    key_in[1087:1024] = 64'hDEAD_BEEF_0000_0001;  // must be ignored when FIRST=1
    tweak_in[63:0]    = 64'h10;
    tweak_in[127:64]  = 64'h20;
    tweak_in[191:128] = 64'h5555;                 // must be ignored when FIRST=1
    in_valid = 1'b1;
    @(posedge clk); #1;
    $display("vec2 k_i=i S=0: w13=%h w14=%h w15=%h", w16(uf_so, 13), w16(uf_so, 14), w16(uf_so, 15));
    for (int i = 0; i < 13; i++) chk($sformatf("v2_w%0d", i), w16(uf_so, i), 64'(i));
    chk("v2_w13", w16(uf_so, 13), 64'h1D);
    chk("v2_w14", w16(uf_so, 14), 64'h2E);
    chk("v2_w15", w16(uf_so, 15), 64'h0F);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("v2_kv_early", {63'd0, uf_kv}, 64'd0);
    @(posedge clk); #1;
    $display("vec2 key line: k16=%h t2=%h kv=%0b", w17(uf_ko, 16), uf_to[191:128], uf_kv);
    chk("v2_kv", {63'd0, uf_kv}, 64'd1);
    chk("v2_k16", w17(uf_ko, 16), C240);
    chk("v2_t2", uf_to[191:128], 64'h30);
    chk("v2_k5", w17(uf_ko, 5), 64'd5);
    chk("v2_passthru_k16", w17(up_ko, 16), 64'hDEAD_BEEF_0000_0001);
    chk("v2_passthru_t2", up_to[191:128], 64'h5555);

    // ---------------- vector 3: wrap, S=0 FIRST=0 ----------------
    @(negedge clk);
    clear_inputs();
    state_in[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    key_in[63:0]   = 64'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    $display("vec3 wrap: w0=%h w1=%h", w16(up_so, 0), w16(up_so, 1));
    chk("v3_w0", w16(up_so, 0), 64'd0);
    chk("v3_w1", w16(up_so, 1), 64'd0);
    @(negedge clk); in_valid = 1'b0;

    // ---------------- vector 4: rotation, S=18 FIRST=0 ----------------
    @(negedge clk);
    clear_inputs();
    for (int j = 0; j < 17; j++) key_in[64*j +: 64] = 64'(j + 1);
    tweak_in = {64'h300, 64'h200, 64'h100};
    in_valid = 1'b1;
    @(posedge clk); #1;
    $display("vec4 rotation S=18: w0=%h w13=%h w14=%h w15=%h",
             w16(u18_so, 0), w16(u18_so, 13), w16(u18_so, 14), w16(u18_so, 15));
    for (int i = 0; i < 13; i++) chk($sformatf("v4_w%0d", i), w16(u18_so, i), 64'(i + 2));
    chk("v4_w13", w16(u18_so, 13), 64'h10F);
    chk("v4_w14", w16(u18_so, 14), 64'h210);
    chk("v4_w15", w16(u18_so, 15), 64'h23);
    @(negedge clk); in_valid = 1'b0;
    repeat (5) @(posedge clk);

    // ---------------- streaming with a bubble ----------------
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      clear_inputs();
      state_in[63:0] = 64'(c * 16);
      key_in[63:0]   = 64'(c + 1);
      in_valid = (c < 8) ? pat[c] : 1'b0;
      @(posedge clk); #1;
      $display("stream c=%0d ov=%0b kv=%0b", c, up_ov, up_kv);
      chk($sformatf("st_ov_%0d", c), {63'd0, up_ov}, {63'd0, (c < 8) ? pat[c] : 1'b0});
      chk($sformatf("st_kv_%0d", c), {63'd0, up_kv},
          {63'd0, (c >= 3 && c < 11) ? pat[c-3] : 1'b0});
      if (c < 8 && pat[c]) begin
        exp_w = 64'(c * 16 + c + 1);
        chk($sformatf("st_w0_%0d", c), w16(up_so, 0), exp_w);
      end
      if (c >= 3 && c < 11 && pat[c-3]) begin
        exp_w = 64'(c - 3 + 1);
        chk($sformatf("st_k0_%0d", c), w17(up_ko, 0), exp_w);
      end
    end

    // ---------------- reset mid-stream ----------------
    @(negedge clk);
    for (int j = 0; j < 17; j++) key_in[64*j +: 64] = 64'(j + 7);
    state_in = {16{64'h1234}};
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    $display("mid-stream reset asserted at %0t", $time);
    chk("mr_zero_uf", all_zero_flag(uf_ov, uf_kv, uf_so, uf_ko, uf_to), 64'd0);
    chk("mr_zero_up", all_zero_flag(up_ov, up_kv, up_so, up_ko, up_to), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    nrst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mr_stale_kv_%0d", c), {63'd0, up_kv}, 64'd0);
    end
    @(negedge clk); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mr_ov_after", {63'd0, up_ov}, 64'd1);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mr_kv_%0d", c), {63'd0, up_kv}, (c == 3) ? 64'd1 : 64'd0);
    end
    $display("mid-stream reset recovery checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
